wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the load-result FIFO entry count; legal values are powers of two, minimum 2.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU/immediate result present this cycle; SHALL NOT be backpressured.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 lsu_valid  input  1  load result offered by the LSU.
REQ-008 lsu_ready  output  1  arbiter accepts the load result this cycle.
REQ-009 lsu_rd  input  5  load destination register.
REQ-010 lsu_data  input  32  load data, already sign/zero-extended.
REQ-011 RegWrite  output  1  register-file write enable, registered.
REQ-012 Write_reg  output  5  register-file write index, registered.
REQ-013 Write_data  output  32  register-file write data, registered.
REQ-014 pending_mask  output  32  bit r set while a valid load to register r is queued; used by the hazard unit.

Function
REQ-015 The block SHALL serialise ALU and load results onto the register file's single write port, issuing at most one write per cycle.
REQ-016 An ALU result with alu_valid=1 and alu_rd!=0 SHALL drive RegWrite=1, Write_reg=alu_rd and Write_data=alu_data on the next posedge (latency 1).
REQ-017 alu_valid with alu_rd=0 SHALL be discarded and SHALL NOT occupy the write port.
REQ-018 lsu_ready SHALL equal (count < DEPTH), from registered count only; a same-cycle dequeue SHALL NOT raise lsu_ready when the FIFO is full.
REQ-019 A load handshake (lsu_valid && lsu_ready) with lsu_rd!=0 SHALL enqueue {rd, data, valid=1} at the FIFO tail.
REQ-020 A load handshake with lsu_rd=0 SHALL complete without enqueuing.
REQ-021 In any cycle where the write port is not claimed by a non-zero-rd ALU result and the FIFO is non-empty, the head SHALL be popped.
REQ-022 A popped head with valid=1 SHALL produce a write on the next posedge.
REQ-023 A popped head with valid=0 (squashed) SHALL produce RegWrite=0 that cycle.
REQ-024 ALU results SHALL have strict priority over the FIFO head.
REQ-025 A write arriving at an empty FIFO SHALL NOT bypass the queue: enqueue this cycle, earliest write two posedges after the handshake.
REQ-026 When an accepted ALU result has rd=X, every queued entry with rd=X SHALL have its valid bit cleared in the same cycle, so the younger ALU value is not overwritten.
REQ-027 An entry enqueued in the same cycle as an ALU result to the same rd SHALL be kept valid, because the load is younger.
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 pending_mask SHALL be the OR of one-hot(rd) over all valid queued entries, registered.
REQ-031 pending_mask SHALL reflect enqueue, pop and squash from the posedge on which they take effect.
REQ-032 When no write is issued, RegWrite SHALL be 0 and Write_reg/Write_data SHALL hold their previous values.
REQ-033 Registered outputs update on posedge; the register file samples them on negedge, giving half-cycle setup.

Reset
REQ-034 While rst_n=0: RegWrite=0, Write_reg=0, Write_data=0, pending_mask=0, lsu_ready=0, count=0, pointers=0, all entry valid bits=0.
REQ-035 Assertion of rst_n=0 SHALL take effect immediately, independent of clk.
REQ-036 Reset mid-operation SHALL discard all queued loads without issuing writes.
REQ-037 lsu_ready SHALL rise on the first posedge after rst_n deasserts.

Verification
REQ-038 ALU only: alu_valid=1, rd=5, data=0x1234 -> next posedge RegWrite=1, Write_reg=5, Write_data=0x1234.
REQ-039 Load only: lsu rd=7, data=0xDEADBEEF with the FIFO empty -> pending_mask[7]=1 after one posedge; write of 7/0xDEADBEEF after the second posedge; pending_mask[7]=0 after it.
REQ-040 Priority and fill (DEPTH=4): 4 loads (rd 1..4) while ALU is valid (rd=9) every cycle -> lsu_ready=0 after the 4th; only rd=9 writes occur. Drop alu_valid -> writes to rd 1,2,3,4 in order on consecutive cycles; lsu_ready returns to 1.
REQ-041 Squash: queue a load with rd=6, then ALU rd=6 data=0xAA -> one write 6/0xAA; pending_mask[6] clears; the later pop of the squashed entry gives RegWrite=0.
REQ-042 x0 filtering: ALU rd=0 and load rd=0 -> no RegWrite, count stays 0, pending_mask stays 0.
REQ-043 Reset with 3 loads queued: rst_n=0 mid-cycle -> outputs 0 and lsu_ready=0 immediately; after release no writes occur and pending_mask=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results take the port directly, load
// results wait in a small FIFO and drain whenever the ALU leaves the port idle.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        RegWrite,
  output logic [4:0]  Write_reg,
  output logic [31:0] Write_data,
  output logic [31:0] pending_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]        count_q, count_d;
  logic               ready_q, ready_d;
  logic               regwrite_q, regwrite_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic [31:0]        write_data_q, write_data_d;
  logic [31:0]        pend_q, pend_d;
  logic               alu_wr, enq, pop;
  entry_t             head;

  always_comb begin
    fifo_d       = fifo_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    alu_wr       = alu_valid && (alu_rd != 5'd0);
    enq          = lsu_valid && ready_q && (lsu_rd != 5'd0);
    pop          = !alu_wr && (count_q != '0);
    head         = fifo_q[rptr_q];

    if (alu_wr) begin
      regwrite_d   = 1'b1;
      write_reg_d  = alu_rd;
      write_data_d = alu_data;
      // Older queued loads to the same register must not clobber the ALU value.
      for (int i = 0; i < DEPTH; i++)
        if (fifo_q[i].rd == alu_rd) fifo_d[i].vld = 1'b0;
    end else if (pop) begin
      regwrite_d = head.vld;
      if (head.vld) begin
        write_reg_d  = head.rd;
        write_data_d = head.data;
      end
      fifo_d[rptr_q].vld = 1'b0;
      rptr_d = rptr_q + 1'b1;
    end

    // Enqueue after the squash so a same-cycle (younger) load stays valid.
    if (enq) begin
      fifo_d[wptr_q] = '{vld: 1'b1, rd: lsu_rd, data: lsu_data};
      wptr_d = wptr_q + 1'b1;
    end

    count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, pop};
    ready_d = count_d < DEPTH_C;

    pend_d = '0;
    for (int i = 0; i < DEPTH; i++)
      if (fifo_d[i].vld) pend_d = pend_d | (32'd1 << fifo_d[i].rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pend_q       <= '0;
    end else begin
      fifo_q       <= fifo_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pend_q       <= pend_d;
    end
  end

  // ready_q tracks count_q < DEPTH but stays low through reset.
  assign lsu_ready    = ready_q;
  assign RegWrite     = regwrite_q;
  assign Write_reg    = write_reg_q;
  assign Write_data   = write_data_q;
  assign pending_mask = pend_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: each task drives one scenario and checks
// registered outputs 1ns after the posedge that produces them.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        RegWrite;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;

  int n_chk = 0;
  int n_fail = 0;

  wb_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .Write_reg(Write_reg), .Write_data(Write_data),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0; lsu_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask, lsu_ready} !== 71'd0) begin
      n_fail++; $display("FAIL reset_async: got %h want 0", {RegWrite, Write_reg, Write_data, pending_mask, lsu_ready});
    end
    tick(); tick();
    rst_n = 1'b1;
    #0;
    n_chk++;
    if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", lsu_ready); end
    tick();
    n_chk++;
    if ({lsu_ready, RegWrite, pending_mask} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL ready_after_release: rdy=%b rw=%b pm=%h want 1 0 0", lsu_ready, RegWrite, pending_mask);
    end
  endtask

  task automatic test_alu;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data} !== {1'b1, 5'd5, 32'h1234}) begin
      n_fail++; $display("FAIL alu_write: got %b/%0d/%h want 1/5/1234", RegWrite, Write_reg, Write_data);
    end
    idle();
    tick();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data} !== {1'b0, 5'd5, 32'h1234}) begin
      n_fail++; $display("FAIL alu_hold: got %b/%0d/%h want 0/5/1234", RegWrite, Write_reg, Write_data);
    end
  endtask

  task automatic test_load;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEADBEEF;
    tick();
    idle();
    n_chk++;
    if ({RegWrite, pending_mask} !== {1'b0, 32'h80}) begin
      n_fail++; $display("FAIL load_enq: rw=%b pm=%h want 0 00000080", RegWrite, pending_mask);
    end
    tick();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask} !== {1'b1, 5'd7, 32'hDEADBEEF, 32'd0}) begin
      n_fail++; $display("FAIL load_write: got %b/%0d/%h pm=%h want 1/7/deadbeef pm=0", RegWrite, Write_reg, Write_data, pending_mask);
    end
    tick();
    n_chk++;
    if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL load_after: rw=%b want 0", RegWrite); end
  endtask

  task automatic test_priority;
    logic [31:0] exp_pm;
    exp_pm = '0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    lsu_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      lsu_rd = 5'(k); lsu_data = 32'h100 + 32'(k);
      exp_pm = exp_pm | (32'd1 << k);
      tick();
      n_chk++;
      if ({RegWrite, Write_reg, pending_mask, lsu_ready} !== {1'b1, 5'd9, exp_pm, (k < 4)}) begin
        n_fail++; $display("FAIL prio_fill%0d: rw=%b rd=%0d pm=%h rdy=%b want 1 9 %h %b", k, RegWrite, Write_reg, pending_mask, lsu_ready, exp_pm, k < 4);
      end
    end
    lsu_rd = 5'd5; lsu_data = 32'h555;
    tick();
    n_chk++;
    if ({Write_reg, pending_mask, lsu_ready} !== {5'd9, 32'h1E, 1'b0}) begin
      n_fail++; $display("FAIL prio_full: rd=%0d pm=%h rdy=%b want 9 1e 0", Write_reg, pending_mask, lsu_ready);
    end
    idle();
    for (int k = 1; k <= 4; k++) begin
      exp_pm = exp_pm & ~(32'd1 << k);
      tick();
      n_chk++;
      if ({RegWrite, Write_reg, Write_data, pending_mask, lsu_ready} !== {1'b1, 5'(k), 32'h100 + 32'(k), exp_pm, 1'b1}) begin
        n_fail++; $display("FAIL prio_drain%0d: got %b/%0d/%h pm=%h rdy=%b want 1/%0d/%h pm=%h rdy=1", k, RegWrite, Write_reg, Write_data, pending_mask, lsu_ready, k, 32'h100 + 32'(k), exp_pm);
      end
    end
    tick();
    n_chk++;
    if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL prio_empty: rw=%b want 0", RegWrite); end
  endtask

  task automatic test_squash;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
    tick();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'hAA;
    tick();
    alu_valid = 1'b0;
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask} !== {1'b1, 5'd6, 32'hAA, 32'd0}) begin
      n_fail++; $display("FAIL squash_alu: got %b/%0d/%h pm=%h want 1/6/aa pm=0", RegWrite, Write_reg, Write_data, pending_mask);
    end
    tick();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data} !== {1'b0, 5'd6, 32'hAA}) begin
      n_fail++; $display("FAIL squash_pop: got %b/%0d/%h want 0/6/aa", RegWrite, Write_reg, Write_data);
    end
  endtask

  task automatic test_same_cycle;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h800;
    tick();
    idle();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask} !== {1'b1, 5'd8, 32'h88, 32'h100}) begin
      n_fail++; $display("FAIL same_alu: got %b/%0d/%h pm=%h want 1/8/88 pm=100", RegWrite, Write_reg, Write_data, pending_mask);
    end
    tick();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask} !== {1'b1, 5'd8, 32'h800, 32'd0}) begin
      n_fail++; $display("FAIL same_load: got %b/%0d/%h pm=%h want 1/8/800 pm=0", RegWrite, Write_reg, Write_data, pending_mask);
    end
  endtask

  task automatic test_x0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBAD0;
    tick(); tick();
    n_chk++;
    if ({RegWrite, pending_mask, lsu_ready} !== {1'b0, 32'd0, 1'b1}) begin
      n_fail++; $display("FAIL x0_drop: rw=%b pm=%h rdy=%b want 0 0 1", RegWrite, pending_mask, lsu_ready);
    end
    idle();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0;
    lsu_rd = 5'd0;
    tick();
    idle();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask} !== {1'b1, 5'd3, 32'h33, 32'd0}) begin
      n_fail++; $display("FAIL x0_noclaim: got %b/%0d/%h pm=%h want 1/3/33 pm=0", RegWrite, Write_reg, Write_data, pending_mask);
    end
    tick();
    n_chk++;
    if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL x0_after: rw=%b want 0", RegWrite); end
  endtask

  task automatic test_back_to_back;
    lsu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lsu_rd = 5'(13 + k); lsu_data = 32'hC0 + 32'(k);
      tick();
      if (k > 0) begin
        n_chk++;
        if ({RegWrite, Write_reg, Write_data, lsu_ready} !== {1'b1, 5'(12 + k), 32'hC0 + 32'(k - 1), 1'b1}) begin
          n_fail++; $display("FAIL b2b_%0d: got %b/%0d/%h rdy=%b want 1/%0d/%h rdy=1", k, RegWrite, Write_reg, Write_data, lsu_ready, 12 + k, 32'hC0 + 32'(k - 1));
        end
      end
    end
    idle();
    tick();
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask} !== {1'b1, 5'd15, 32'hC2, 32'd0}) begin
      n_fail++; $display("FAIL b2b_last: got %b/%0d/%h pm=%h want 1/15/c2 pm=0", RegWrite, Write_reg, Write_data, pending_mask);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lsu_rd = 5'(10 + k); lsu_data = 32'hA0 + 32'(k);
      tick();
    end
    idle();
    n_chk++;
    if (pending_mask !== 32'h1C00) begin n_fail++; $display("FAIL rstmid_queued: pm=%h want 1c00", pending_mask); end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({RegWrite, Write_reg, Write_data, pending_mask, lsu_ready} !== 71'd0) begin
      n_fail++; $display("FAIL rstmid_async: got %h want 0", {RegWrite, Write_reg, Write_data, pending_mask, lsu_ready});
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_chk++;
      if ({RegWrite, pending_mask, lsu_ready} !== {1'b0, 32'd0, 1'b1}) begin
        n_fail++; $display("FAIL rstmid_after%0d: rw=%b pm=%h rdy=%b want 0 0 1", k, RegWrite, pending_mask, lsu_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_priority();
    test_squash();
    test_same_cycle();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
